breakout_game_ctrl: RTL and testbench
=====================================

# breakout_game_ctrl

Game-flow sequencer for the breakout VGA game. Sits between the button inputs, the ball/paddle/brick datapath and the display. It debounces the buttons once per frame, runs the title/serve/play/lost/clear/over state machine, keeps lives, score, level and remaining-brick count, and issues enable and one-shot control pulses to the datapath.

## Interface
- NUM_BRICKS, 40: bricks per level; remaining-brick counter reload value (≥1).
- START_LIVES, 3: lives loaded at game start (1..7).
- PAUSE_FRAMES, 60: frames spent in LOST and CLEAR (1..255).
- SCORE_W, 12: score width; score saturates at 2^SCORE_W−1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system/pixel clock.
- rst  in  1  asynchronous active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (start of vblank).
- btn_left, btn_right, btn_select  in  1 each  raw button levels, already synchronised to clk.
- ball_lost  in  1  one-cycle pulse: ball passed the paddle.
- brick_hit  in  1  one-cycle pulse: one brick destroyed.
- game_state  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 LOST, 4 CLEAR, 5 OVER.
- ball_run  out  1  ball motion enable.
- paddle_left, paddle_right  out  1 each  paddle move levels.
- ball_reset  out  1  one-cycle pulse: park ball on paddle.
- bricks_reload  out  1  one-cycle pulse: restore brick field.
- lives  out  3  remaining lives.
- score  out  SCORE_W  bricks destroyed this game.
- level  out  3  current level, 0..7.

## Operation
- Debounce, per button, sampled only on frame_tick: sh <= btn; stable <= 1 if sh&btn, 0 if ~sh&~btn, else held. sel_press register = one-cycle pulse the cycle after stable_select rises.
- paddle_left = stable_left & ~stable_right, paddle_right = stable_right & ~stable_left, only in SERVE/PLAY; otherwise 0.
- ball_run = 1 only in PLAY.
- IDLE: on sel_press → SERVE; load lives=START_LIVES, score=0, level=0, bricks=NUM_BRICKS; pulse bricks_reload and ball_reset.
- SERVE: on sel_press → PLAY.
- PLAY: brick_hit → score+1 (saturating), bricks−1. ball_lost → lives−1.
- PLAY priority when both in the same cycle: brick_hit is counted first; if bricks reaches 0 → CLEAR and no life is lost. Otherwise ball_lost applies: lives was 1 → OVER (lives=0), else → LOST.
- LOST: count frame_tick; on the PAUSE_FRAMES-th tick → SERVE with a ball_reset pulse.
- CLEAR: count frame_tick; on the PAUSE_FRAMES-th tick → SERVE; level+1 (saturating at 7); bricks=NUM_BRICKS; pulse bricks_reload and ball_reset.
- OVER: score and level held; sel_press → IDLE. lives, score and level keep their values in IDLE until the next start.
- ball_lost and brick_hit outside PLAY are ignored. sel_press outside IDLE/SERVE/OVER is ignored.
- Pause counter clears on every entry to LOST/CLEAR.

## Timing
- Reset (async, any state, mid-pause included) gives:
  - game_state=IDLE; all outputs 0 (lives=0, score=0, level=0, pulses 0, ball_run 0).
  - bricks=NUM_BRICKS; debounce registers and pause counter 0.
- All outputs are registered. game_state changes on the clk edge where the condition is sampled.
- ball_reset and bricks_reload are high for exactly the first cycle of the new state.
- Button latency: the level must be present at two consecutive frame_ticks. stable updates at the second tick edge. sel_press is high the next cycle. The state changes on the edge after that (2 clk after the second tick edge).
- Score, lives and bricks update on the edge that samples the event pulse. Back-to-back pulses on consecutive cycles are each counted.
- Pause: leave on the edge sampling the PAUSE_FRAMES-th frame_tick after entry. A tick in the entry cycle itself is not counted.

## Test plan
- Reset mid-LOST with pause count 30 → next cycle IDLE, lives=0, score=0, ball_run=0, no pulses.
- Select held 3 frames in IDLE → SERVE exactly 2 clk after the 2nd sampled tick; lives=3; bricks_reload and ball_reset each 1 cycle. A 1-frame glitch causes no transition.
- In PLAY, send 39 brick_hit → score=39, still PLAY. The 40th hit in the same cycle as ball_lost → CLEAR, lives unchanged. After 60 ticks → SERVE with level=1 and both pulses.
- Lives=1 in PLAY, ball_lost → OVER, lives=0, ball_run=0. sel_press → IDLE with score held.
- SCORE_W=4: 20 hits across levels → score saturates at 15. Level after 8 clears saturates at 7.
- Left+right both held → both paddle outputs 0. Left only in OVER → paddle_left=0.

Source files
------------

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: game-flow sequencer for the breakout VGA game.
// Debounces the three buttons once per frame, runs the
// IDLE/SERVE/PLAY/LOST/CLEAR/OVER flow, and keeps lives, score, level
// and the remaining-brick count. It drives motion enables and one-shot
// ball_reset / bricks_reload pulses to the ball/paddle/brick datapath.
// Every output comes straight from a flip-flop.

module breakout_game_ctrl #(
  parameter int NUM_BRICKS   = 40,
  parameter int START_LIVES  = 3,
  parameter int PAUSE_FRAMES = 60,
  parameter int SCORE_W      = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_select,
  input  logic               ball_lost,
  input  logic               brick_hit,
  output logic [2:0]         game_state,
  output logic               ball_run,
  output logic               paddle_left,
  output logic               paddle_right,
  output logic               ball_reset,
  output logic               bricks_reload,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         level
);

  // State encoding matches the game_state output.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_LOST  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam int                 BRICK_W     = $clog2(NUM_BRICKS + 1);
  localparam logic [BRICK_W-1:0] BRICKS_FULL = BRICK_W'(NUM_BRICKS);
  localparam logic [BRICK_W-1:0] BRICK_ONE   = BRICK_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);
  localparam logic [7:0]         PAUSE_LAST  = 8'(PAUSE_FRAMES - 1);
  localparam logic [2:0]         LIVES_START = 3'(START_LIVES);
  localparam logic [2:0]         LEVEL_MAX   = 3'd7;

  // Button vectors are ordered {select, right, left}.
  localparam int B_LEFT   = 0;
  localparam int B_RIGHT  = 1;
  localparam int B_SELECT = 2;

  logic [2:0]         w_btn;
  logic [2:0]         r_sh;
  logic [2:0]         r_stable;
  logic [2:0]         w_stable_nxt;
  logic               r_sel_prev;
  logic               r_sel_press;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [2:0]         r_lives;
  logic [2:0]         w_lives_nxt;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [2:0]         r_level;
  logic [2:0]         w_level_nxt;
  logic [BRICK_W-1:0] r_bricks;
  logic [BRICK_W-1:0] w_bricks_nxt;
  logic [7:0]         r_pause;
  logic [7:0]         w_pause_nxt;
  logic               w_ball_reset_nxt;
  logic               w_bricks_reload_nxt;
  logic               w_move_en_nxt;

  logic               r_ball_run;
  logic               r_paddle_left;
  logic               r_paddle_right;
  logic               r_ball_reset;
  logic               r_bricks_reload;

  assign w_btn = {btn_select, btn_right, btn_left};

  // Debounce: on a frame tick a button whose previous and current samples
  // agree takes that level; a disagreeing pair holds the old stable value.
  assign w_stable_nxt = frame_tick ? ((r_sh & w_btn) | (r_stable & (r_sh ^ w_btn)))
                                   : r_stable;

  // Frame-rate button sampling and select rising-edge detection.
  // NOTE: every register uses <= so all flops see pre-edge values; a
  // blocking assignment here would let r_stable see this edge's r_sh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh        <= '0;
      r_stable    <= '0;
      r_sel_prev  <= 1'b0;
      r_sel_press <= 1'b0;
    end else begin
      if (frame_tick) begin
        r_sh <= w_btn;
      end
      r_stable    <= w_stable_nxt;
      r_sel_prev  <= r_stable[B_SELECT];
      r_sel_press <= r_stable[B_SELECT] & ~r_sel_prev;
    end
  end

  // Game-flow next-state and bookkeeping logic.
  // NOTE: every target gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt         = r_state;
    w_lives_nxt         = r_lives;
    w_score_nxt         = r_score;
    w_level_nxt         = r_level;
    w_bricks_nxt        = r_bricks;
    w_pause_nxt         = r_pause;
    w_ball_reset_nxt    = 1'b0;
    w_bricks_reload_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_sel_press) begin
          w_state_nxt         = S_SERVE;
          w_lives_nxt         = LIVES_START;
          w_score_nxt         = '0;
          w_level_nxt         = '0;
          w_bricks_nxt        = BRICKS_FULL;
          w_ball_reset_nxt    = 1'b1;
          w_bricks_reload_nxt = 1'b1;
        end
      end

      S_SERVE: begin
        if (r_sel_press) begin
          w_state_nxt = S_PLAY;
        end
      end

      S_PLAY: begin
        if (brick_hit) begin
          if (r_score != SCORE_MAX) begin
            w_score_nxt = r_score + SCORE_ONE;
          end
          w_bricks_nxt = r_bricks - BRICK_ONE;
        end
        // Clearing the last brick wins over a simultaneous ball loss.
        if (brick_hit && (r_bricks == BRICK_ONE)) begin
          w_state_nxt = S_CLEAR;
          w_pause_nxt = '0;
        end else if (ball_lost) begin
          w_pause_nxt = '0;
          if (r_lives == 3'd1) begin
            w_state_nxt = S_OVER;
            w_lives_nxt = '0;
          end else begin
            w_state_nxt = S_LOST;
            w_lives_nxt = r_lives - 3'd1;
          end
        end
      end

      S_LOST: begin
        if (frame_tick) begin
          if (r_pause == PAUSE_LAST) begin
            w_state_nxt      = S_SERVE;
            w_ball_reset_nxt = 1'b1;
          end else begin
            w_pause_nxt = r_pause + 8'd1;
          end
        end
      end

      S_CLEAR: begin
        if (frame_tick) begin
          if (r_pause == PAUSE_LAST) begin
            w_state_nxt         = S_SERVE;
            w_bricks_nxt        = BRICKS_FULL;
            w_ball_reset_nxt    = 1'b1;
            w_bricks_reload_nxt = 1'b1;
            if (r_level != LEVEL_MAX) begin
              w_level_nxt = r_level + 3'd1;
            end
          end else begin
            w_pause_nxt = r_pause + 8'd1;
          end
        end
      end

      S_OVER: begin
        if (r_sel_press) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Paddle motion is only allowed while a ball is being served or played.
  assign w_move_en_nxt = (w_state_nxt == S_SERVE) || (w_state_nxt == S_PLAY);

  // Game-flow registers; outputs are registered from next-state values so
  // they line up with game_state on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_lives         <= '0;
      r_score         <= '0;
      r_level         <= '0;
      r_bricks        <= BRICKS_FULL;
      r_pause         <= '0;
      r_ball_run      <= 1'b0;
      r_paddle_left   <= 1'b0;
      r_paddle_right  <= 1'b0;
      r_ball_reset    <= 1'b0;
      r_bricks_reload <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_lives         <= w_lives_nxt;
      r_score         <= w_score_nxt;
      r_level         <= w_level_nxt;
      r_bricks        <= w_bricks_nxt;
      r_pause         <= w_pause_nxt;
      r_ball_run      <= (w_state_nxt == S_PLAY);
      r_paddle_left   <= w_move_en_nxt & w_stable_nxt[B_LEFT]  & ~w_stable_nxt[B_RIGHT];
      r_paddle_right  <= w_move_en_nxt & w_stable_nxt[B_RIGHT] & ~w_stable_nxt[B_LEFT];
      r_ball_reset    <= w_ball_reset_nxt;
      r_bricks_reload <= w_bricks_reload_nxt;
    end
  end

  assign game_state    = r_state;
  assign ball_run      = r_ball_run;
  assign paddle_left   = r_paddle_left;
  assign paddle_right  = r_paddle_right;
  assign ball_reset    = r_ball_reset;
  assign bricks_reload = r_bricks_reload;
  assign lives         = r_lives;
  assign score         = r_score;
  assign level         = r_level;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// tb_breakout_game_ctrl: directed scenarios followed by random stimulus,
// all checked every cycle against a behavioural model of the game rules.

module tb_breakout_game_ctrl;

  localparam int NB   = 40;
  localparam int SL   = 3;
  localparam int PF   = 60;
  localparam int SW   = 6;
  localparam int SMAX = (1 << SW) - 1;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_LOST  = 3;
  localparam int S_CLEAR = 4;
  localparam int S_OVER  = 5;

  logic          clk;
  logic          rst;
  logic          frame_tick;
  logic          btn_left;
  logic          btn_right;
  logic          btn_select;
  logic          ball_lost;
  logic          brick_hit;
  logic [2:0]    game_state;
  logic          ball_run;
  logic          paddle_left;
  logic          paddle_right;
  logic          ball_reset;
  logic          bricks_reload;
  logic [2:0]    lives;
  logic [SW-1:0] score;
  logic [2:0]    level;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state, expressed in game terms.
  int m_state;
  int m_lives;
  int m_score;
  int m_level;
  int m_bricks;
  int m_ticks_in_pause;
  bit m_ball_reset;
  bit m_bricks_reload;
  bit m_last[3];     // last level seen on a frame tick, per button
  bit m_stable[3];   // debounced level, per button
  int m_edge;        // clock edges since reset
  int m_rise_edge;   // edge at which debounced select last rose

  breakout_game_ctrl #(
    .NUM_BRICKS  (NB),
    .START_LIVES (SL),
    .PAUSE_FRAMES(PF),
    .SCORE_W     (SW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_select   (btn_select),
    .ball_lost    (ball_lost),
    .brick_hit    (brick_hit),
    .game_state   (game_state),
    .ball_run     (ball_run),
    .paddle_left  (paddle_left),
    .paddle_right (paddle_right),
    .ball_reset   (ball_reset),
    .bricks_reload(bricks_reload),
    .lives        (lives),
    .score        (score),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state         = S_IDLE;
    m_lives         = 0;
    m_score         = 0;
    m_level         = 0;
    m_bricks        = NB;
    m_ticks_in_pause = 0;
    m_ball_reset    = 0;
    m_bricks_reload = 0;
    for (int i = 0; i < 3; i++) begin
      m_last[i]   = 0;
      m_stable[i] = 0;
    end
    m_edge      = 0;
    m_rise_edge = -100;
  endtask

  // One clock edge of the game rules, applied to the inputs seen at the edge.
  task automatic model_edge();
    bit btn[3];
    bit sel_event;
    bit was_sel;
    btn[0] = btn_left;
    btn[1] = btn_right;
    btn[2] = btn_select;
    m_edge++;
    // A select press acts two edges after the debounced level rose.
    sel_event = (m_edge == m_rise_edge + 2);
    if (frame_tick) begin
      was_sel = m_stable[2];
      for (int i = 0; i < 3; i++) begin
        if (m_last[i] == btn[i]) m_stable[i] = btn[i];
        m_last[i] = btn[i];
      end
      if (!was_sel && m_stable[2]) m_rise_edge = m_edge;
    end
    m_ball_reset    = 0;
    m_bricks_reload = 0;
    case (m_state)
      S_IDLE: if (sel_event) begin
        m_state = S_SERVE;
        m_lives = SL;
        m_score = 0;
        m_level = 0;
        m_bricks = NB;
        m_ball_reset = 1;
        m_bricks_reload = 1;
      end
      S_SERVE: if (sel_event) m_state = S_PLAY;
      S_PLAY: begin
        if (brick_hit) begin
          if (m_score < SMAX) m_score++;
          m_bricks--;
        end
        if (brick_hit && m_bricks == 0) begin
          m_state = S_CLEAR;
          m_ticks_in_pause = 0;
        end else if (ball_lost) begin
          m_ticks_in_pause = 0;
          m_lives--;
          m_state = (m_lives == 0) ? S_OVER : S_LOST;
        end
      end
      S_LOST: if (frame_tick) begin
        m_ticks_in_pause++;
        if (m_ticks_in_pause == PF) begin
          m_state = S_SERVE;
          m_ball_reset = 1;
        end
      end
      S_CLEAR: if (frame_tick) begin
        m_ticks_in_pause++;
        if (m_ticks_in_pause == PF) begin
          m_state = S_SERVE;
          m_bricks = NB;
          m_level = (m_level < 7) ? m_level + 1 : 7;
          m_ball_reset = 1;
          m_bricks_reload = 1;
        end
      end
      S_OVER: if (sel_event) m_state = S_IDLE;
      default: m_state = S_IDLE;
    endcase
  endtask

  task automatic check_all();
    bit move;
    move = (m_state == S_SERVE) || (m_state == S_PLAY);
    check("game_state",    game_state,    m_state);
    check("lives",         lives,         m_lives);
    check("score",         score,         m_score);
    check("level",         level,         m_level);
    check("ball_run",      ball_run,      m_state == S_PLAY);
    check("paddle_left",   paddle_left,   move && m_stable[0] && !m_stable[1]);
    check("paddle_right",  paddle_right,  move && m_stable[1] && !m_stable[0]);
    check("ball_reset",    ball_reset,    m_ball_reset);
    check("bricks_reload", bricks_reload, m_bricks_reload);
  endtask

  // One clock: model at the edge, compare at the falling edge, drop pulses.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    check_all();
    frame_tick = 0;
    brick_hit  = 0;
    ball_lost  = 0;
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      frame_tick = 1;
      step();
      repeat (3) step();
    end
  endtask

  task automatic press_select();
    btn_select = 1;
    frames(3);
    btn_select = 0;
    frames(3);
  endtask

  initial begin
    rst = 1; frame_tick = 0; btn_left = 0; btn_right = 0; btn_select = 0;
    ball_lost = 0; brick_hit = 0;
    model_reset();
    repeat (2) step();
    rst = 0;
    step();
    check("reset_state", game_state, S_IDLE);

    // One-frame select glitch: no start.
    btn_select = 1;
    frames(1);
    btn_select = 0;
    frames(3);
    check("glitch_idle", game_state, S_IDLE);

    // Select held: SERVE exactly two clocks after the second sampled tick.
    btn_select = 1;
    frame_tick = 1; step();
    repeat (3) step();
    frame_tick = 1; step();
    step();
    check("start_still_idle", game_state, S_IDLE);
    step();
    check("start_serve", game_state, S_SERVE);
    check("start_lives", lives, SL);
    check("start_ball_reset", ball_reset, 1);
    check("start_bricks_reload", bricks_reload, 1);
    step();
    check("start_pulse_end", ball_reset | bricks_reload, 0);
    frames(1);
    btn_select = 0;
    frames(3);

    // Into PLAY, paddles.
    press_select();
    check("play", game_state, S_PLAY);
    btn_left = 1;
    frames(2);
    check("paddle_left_only", paddle_left, 1);
    btn_right = 1;
    frames(2);
    check("both_held", {paddle_left, paddle_right}, 0);
    btn_left = 0; btn_right = 0;
    frames(2);

    // 39 back-to-back hits, then the last hit together with a lost ball.
    for (int i = 0; i < NB - 1; i++) begin
      brick_hit = 1;
      step();
    end
    check("score_39", score, NB - 1);
    check("still_play", game_state, S_PLAY);
    brick_hit = 1; ball_lost = 1;
    step();
    check("clear", game_state, S_CLEAR);
    check("clear_lives", lives, SL);
    frames(PF - 1);
    check("clear_waiting", game_state, S_CLEAR);
    frame_tick = 1;
    step();
    check("clear_to_serve", game_state, S_SERVE);
    check("clear_level", level, 1);
    check("clear_ball_reset", ball_reset, 1);
    check("clear_bricks_reload", bricks_reload, 1);
    repeat (3) step();

    // Lose a ball, reset mid-pause.
    press_select();
    ball_lost = 1;
    step();
    check("lost", game_state, S_LOST);
    check("lost_lives", lives, SL - 1);
    frames(30);
    check("lost_mid_pause", game_state, S_LOST);
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    check("async_reset_state", game_state, S_IDLE);
    step();
    rst = 0;
    step();
    check("after_reset_lives", lives, 0);

    // Lose every life.
    press_select();
    press_select();
    for (int i = 0; i < 5; i++) begin
      brick_hit = 1;
      step();
    end
    for (int l = SL; l > 1; l--) begin
      ball_lost = 1;
      step();
      frames(PF);
      check("lost_back_to_serve", game_state, S_SERVE);
      press_select();
    end
    ball_lost = 1;
    step();
    check("over", game_state, S_OVER);
    check("over_lives", lives, 0);
    check("over_ball_run", ball_run, 0);
    btn_left = 1;
    frames(2);
    check("over_paddle_left", paddle_left, 0);
    btn_left = 0;
    frames(2);
    press_select();
    check("over_to_idle", game_state, S_IDLE);
    check("idle_score_held", score, 5);

    // Eight clears: score and level saturate.
    press_select();
    press_select();
    for (int lv = 0; lv < 8; lv++) begin
      for (int i = 0; i < NB; i++) begin
        brick_hit = 1;
        step();
      end
      frames(PF);
      press_select();
    end
    check("level_sat", level, 7);
    check("score_sat", score, SMAX);

    // Random play.
    for (int i = 0; i < 5000; i++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      brick_hit  = ($urandom_range(0, 5) == 0);
      ball_lost  = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 40) == 0) btn_select = ~btn_select;
      if ($urandom_range(0, 30) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 30) == 0) btn_right = ~btn_right;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
